if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 21 ++
 rtl/if_stage_if.sv | 38 +++
 rtl/if_stage_r_if_id.sv | 48 ++++
 rtl/if_stage.sv | 86 ++++++++
 tb/tb_if_stage.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg -- constants shared by the instruction-fetch stage.
//   PC_W       : program counter / address width
//   RESET_PC   : address fetched first after reset
//   NOP_INSTR  : sll $0,$0,0, loaded into IF/ID on squash and at reset
//   PC_STEP    : byte increment between sequential instructions
//   jump_target(): J-type target built from the IF/ID PC+4 and instruction
package if_stage_pkg;

  localparam int PC_W = 32;

  localparam logic [PC_W-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0]     NOP_INSTR = 32'h0000_0000;
  localparam logic [PC_W-1:0] PC_STEP   = 32'd4;

  // Upper nibble comes from the delay-slot PC+4, not from the jump's own PC.
  function automatic logic [PC_W-1:0] jump_target(input logic [PC_W-1:0] next_pc,
                                                  input logic [31:0]     instr);
    return {next_pc[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// if_stage_if -- control, instruction-memory and IF/ID signals of the fetch stage.
//   slave  modport : seen by if_stage (control + imem data in; PC, IF/ID out)
//   master modport : seen by the surrounding pipeline / memory model
// Optional macro IF_PERF_CNT_EN adds o_fetch_cnt / o_stall_cnt.
interface if_stage_if;
  import if_stage_pkg::*;

  logic            i_stall;
  logic            i_flush;
  logic            i_jump;
  logic            i_branch_taken;
  logic [PC_W-1:0] i_branch_target;
  logic [PC_W-1:0] o_imem_addr;
  logic [31:0]     i_imem_data;
  logic [PC_W-1:0] o_next_pc;
  logic [31:0]     o_instr;
`ifdef IF_PERF_CNT_EN
  logic [31:0]     o_fetch_cnt;
  logic [31:0]     o_stall_cnt;
`endif

  modport slave (
    input  i_stall, i_flush, i_jump, i_branch_taken, i_branch_target, i_imem_data,
`ifdef IF_PERF_CNT_EN
    output o_fetch_cnt, o_stall_cnt,
`endif
    output o_imem_addr, o_next_pc, o_instr
  );

  modport master (
    output i_stall, i_flush, i_jump, i_branch_taken, i_branch_target, i_imem_data,
`ifdef IF_PERF_CNT_EN
    input  o_fetch_cnt, o_stall_cnt,
`endif
    input  o_imem_addr, o_next_pc, o_instr
  );

endinterface

// File: rtl/if_stage_r_if_id.sv
// R_IF_ID -- IF/ID pipeline register (PC+4 and instruction word).
//   i_clk, i_rst_n : clock, asynchronous active-low reset (loads NOP / 0)
//   i_pc4, i_instr : values captured when neither flushing nor holding
//   i_hold         : keep current contents
//   i_flush        : load NOP with PC+4 = 0; takes priority over i_hold
//   o_pc4, o_instr : registered contents
module R_IF_ID
  import if_stage_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [PC_W-1:0] i_pc4,
  input  logic [31:0]     i_instr,
  input  logic            i_hold,
  input  logic            i_flush,
  output logic [PC_W-1:0] o_pc4,
  output logic [31:0]     o_instr
);

  logic [PC_W-1:0] pc4_q, pc4_d;
  logic [31:0]     instr_q, instr_d;

  always_comb begin
    pc4_d   = pc4_q;
    instr_d = instr_q;
    if (i_flush) begin
      pc4_d   = '0;
      instr_d = NOP_INSTR;
    end else if (!i_hold) begin
      pc4_d   = i_pc4;
      instr_d = i_instr;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc4_q   <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
    end
  end

  assign o_pc4   = pc4_q;
  assign o_instr = instr_q;

endmodule

// File: rtl/if_stage.sv
// if_stage -- instruction fetch: PC register, next-PC mux and IF/ID register.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset (PC = RESET_PC, IF/ID = NOP)
//   bus     : if_stage_if.slave (stall/flush/jump/branch control, imem
//             address/data, registered o_next_pc / o_instr)
// Optional macro IF_PERF_CNT_EN adds fetch and stall counters on the bus.
module if_stage
  import if_stage_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  if_stage_if.slave  bus
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc4;
  logic [PC_W-1:0] ifid_pc4;
  logic [31:0]     ifid_instr;
  logic            jump_go;
  logic            squash;

  assign pc4 = pc_q + PC_STEP;  // 32-bit wrap is intended

  // A jump seen during a stall is dropped; ID presents it again afterwards.
  assign jump_go = bus.i_jump && !bus.i_stall;
  assign squash  = bus.i_branch_taken || bus.i_flush || jump_go;

  always_comb begin
    pc_d = pc_q;
    if (bus.i_branch_taken)
      pc_d = bus.i_branch_target;
    else if (jump_go)
      pc_d = jump_target(ifid_pc4, ifid_instr);
    else if (!bus.i_stall)
      pc_d = pc4;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) pc_q <= RESET_PC;
    else          pc_q <= pc_d;
  end

  R_IF_ID u_r_if_id (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_pc4   (pc4),
    .i_instr (bus.i_imem_data),
    .i_hold  (bus.i_stall),
    .i_flush (squash),
    .o_pc4   (ifid_pc4),
    .o_instr (ifid_instr)
  );

  assign bus.o_imem_addr = pc_q;
  assign bus.o_next_pc   = ifid_pc4;
  assign bus.o_instr     = ifid_instr;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    // Counts only real words actually captured into IF/ID.
    if (!squash && !bus.i_stall && (bus.i_imem_data != NOP_INSTR))
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (bus.i_stall)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.o_fetch_cnt = fetch_cnt_q;
  assign bus.o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage -- directed self-checking bench for if_stage.
// Instruction memory model: word at byte address A is (A>>2)+1 unless an
// override word is forced. Inputs change on the falling edge; outputs are
// checked on the following falling edge.
module tb_if_stage;
  import if_stage_pkg::*;

  logic clk;
  logic rst_n;
  logic        ovr_en;
  logic [31:0] ovr_val;
  int checks;
  int failures;
  int cyc;

  if_stage_if bus();

  if_stage u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  assign bus.i_imem_data = ovr_en ? ovr_val : ((bus.o_imem_addr >> 2) + 32'd1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    $display("cyc %0d: addr=%08h instr=%08h next_pc=%08h", cyc,
             bus.o_imem_addr, bus.o_instr, bus.o_next_pc);
  endtask

  task automatic expect_state(input string tag, input logic [31:0] addr,
                              input logic [31:0] instr, input logic [31:0] npc);
    check_eq({tag, ".addr"},  bus.o_imem_addr, addr);
    check_eq({tag, ".instr"}, bus.o_instr,     instr);
    check_eq({tag, ".npc"},   bus.o_next_pc,   npc);
  endtask

  initial begin
`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_base;
`endif
    checks = 0; failures = 0; cyc = 0;
    rst_n = 1'b0; ovr_en = 1'b0; ovr_val = '0;
    bus.i_stall = 1'b0; bus.i_flush = 1'b0; bus.i_jump = 1'b0;
    bus.i_branch_taken = 1'b0; bus.i_branch_target = '0;

    // Reset state, before any clock edge.
    #2;
    expect_state("reset", 32'h0, 32'h0, 32'h0);
    tick(); tick();
    rst_n = 1'b1;

    // Straight-line fetch 1,2,3.
    tick(); expect_state("seq1", 32'h4, 32'h1, 32'h4);
    tick(); expect_state("seq2", 32'h8, 32'h2, 32'h8);
    tick(); expect_state("seq3", 32'hC, 32'h3, 32'hC);
`ifdef IF_PERF_CNT_EN
    check_eq("fetch_cnt", bus.o_fetch_cnt, 32'd3);
    check_eq("stall_cnt0", bus.o_stall_cnt, 32'd0);
`endif

    // Synchronous-side reset again, then stall two cycles at PC=8.
    rst_n = 1'b0;
    #1 expect_state("rst2", 32'h0, 32'h0, 32'h0);
    tick();
    rst_n = 1'b1;
    tick(); expect_state("pre_stall1", 32'h4, 32'h1, 32'h4);
    tick(); expect_state("pre_stall2", 32'h8, 32'h2, 32'h8);
`ifdef IF_PERF_CNT_EN
    stall_base = bus.o_stall_cnt;
`endif
    bus.i_stall = 1'b1;
    tick(); expect_state("stall1", 32'h8, 32'h2, 32'h8);
    tick(); expect_state("stall2", 32'h8, 32'h2, 32'h8);
    bus.i_stall = 1'b0;
`ifdef IF_PERF_CNT_EN
    check_eq("stall_cnt", bus.o_stall_cnt, stall_base + 32'd2);
`endif
    tick(); expect_state("post_stall", 32'hC, 32'h3, 32'hC);

    // Jump word fetched at 0xC; jump held off by stall, then taken.
    ovr_en = 1'b1; ovr_val = 32'h0800_0010;
    tick(); expect_state("jload", 32'h10, 32'h0800_0010, 32'h10);
    ovr_en = 1'b0;
    bus.i_jump = 1'b1; bus.i_stall = 1'b1;
    tick(); expect_state("jstall", 32'h10, 32'h0800_0010, 32'h10);
    bus.i_stall = 1'b0;
    tick(); expect_state("jump", 32'h40, 32'h0, 32'h0);
    bus.i_jump = 1'b0;
    tick(); expect_state("jpost", 32'h44, 32'h11, 32'h44);

    // Branch together with stall: branch wins.
    bus.i_branch_taken = 1'b1; bus.i_branch_target = 32'h100; bus.i_stall = 1'b1;
    tick(); expect_state("br_stall", 32'h100, 32'h0, 32'h0);
    bus.i_branch_taken = 1'b0; bus.i_stall = 1'b0;
    tick(); expect_state("br_post", 32'h104, 32'h41, 32'h104);

    // Flush alone squashes IF/ID but PC keeps advancing.
    bus.i_flush = 1'b1;
    tick(); expect_state("flush", 32'h108, 32'h0, 32'h0);
    bus.i_flush = 1'b0;
    tick(); expect_state("fl_post", 32'h10C, 32'h43, 32'h10C);

    // PC wrap from the top of the address space.
    bus.i_branch_taken = 1'b1; bus.i_branch_target = 32'hFFFF_FFFC;
    tick(); expect_state("br_top", 32'hFFFF_FFFC, 32'h0, 32'h0);
    bus.i_branch_taken = 1'b0;
    tick(); expect_state("wrap", 32'h0, 32'h4000_0000, 32'h0);
    tick(); expect_state("wrap_post", 32'h4, 32'h1, 32'h4);

    // Asynchronous reset in the middle of a jump cycle.
    bus.i_jump = 1'b1;
    #2 rst_n = 1'b0;
    #1 expect_state("rst_async", 32'h0, 32'h0, 32'h0);
    tick(); expect_state("rst_hold", 32'h0, 32'h0, 32'h0);
    bus.i_jump = 1'b0;
    rst_n = 1'b1;
    tick(); expect_state("rst_resume", 32'h4, 32'h1, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
